battle_hp_engine: RTL
=====================

// Module: battle_hp_engine
// PURPOSE
//  Sequential successor to the single-hit HP calculator. Holds the HP and faint state of NUM_POKE
//  combatants. For each attack request it does a type-effectiveness lookup and a stat comparison,
//  then a saturating HP subtraction. One valid/ready transaction per attack; sits between battle FSM and HUD.
// PARAMETERS
//  NUM_POKE  2        number of combatant channels (>=2)
//  HP_W      6        HP / damage width
//  STAT_W    4        attack/defense stat width
//  MAX_HP    63       HP loaded at reset (must fit HP_W)
//  DMG_HI    16       base damage, super-effective
//  DMG_MID   12       base damage, normal
//  DMG_LO    8        base damage, weak
//  DMG_STEP  4        bonus damage when atk_stat > def_stat
//  EFF_TABLE 128'h0   2 bits per {atk_type,def_type} pair (index i=atk*8+def, bits[2i+1:2i]):
//                     00 normal, 01 super, 10 weak, 11 immune (damage 0)
//  IDX_W = max(1,$clog2(NUM_POKE)) (localparam)
// PORTS
//  clk         in   1               system clock
//  reset_n     in   1               async active-low reset
//  init_valid  in   1               load HP for one channel
//  init_idx    in   IDX_W           channel to load
//  init_hp     in   HP_W            HP value to load
//  req_valid   in   1               attack request
//  req_ready   out  1               engine can accept request
//  req_atk_idx in   IDX_W           attacking channel
//  req_def_idx in   IDX_W           defending channel
//  req_atk     in   STAT_W          attacker attack stat
//  req_def     in   STAT_W          defender defense stat
//  req_atk_typ in   3               attacker type
//  req_def_typ in   3               defender type
//  resp_valid  out  1               result available
//  resp_ready  in   1               consumer takes result
//  resp_dmg    out  HP_W            damage applied
//  resp_hp     out  HP_W            defender HP after hit
//  resp_faint  out  1               defender fainted on this hit
//  resp_err    out  1               request rejected (no HP change)
//  hp_o        out  NUM_POKE*HP_W   live HP, channel k at [k*HP_W +: HP_W]
//  faint_o     out  NUM_POKE        sticky faint flag per channel
// BEHAVIOUR
//  Reset (async, any state): all hp = MAX_HP, faint_o = 0, FSM = IDLE, resp_* = 0, req_ready = 0 while
//  reset_n low. In-flight request is dropped with no response.
//  FSM: IDLE -> LOOKUP -> APPLY -> DONE -> IDLE.
//   IDLE:   req_ready = !init_valid. Request accepted on req_valid && req_ready; all req_* registered.
//   LOOKUP: eff code from EFF_TABLE; base = DMG_HI/MID/LO per code, +DMG_STEP if atk>def (unsigned).
//           Immune gives dmg 0. Intermediate sums are HP_W+1 wide; dmg clamps to 2^HP_W-1.
//   APPLY:  err if atk_idx==def_idx, idx>=NUM_POKE, or either channel already fainted.
//           err: dmg=0, hp unchanged. Otherwise, if hp<=dmg and dmg!=0: hp=0, faint set, resp_faint=1.
//           Else hp -= dmg.
//   DONE:   resp_valid=1, resp_* held stable until resp_ready; returns to IDLE the cycle after
//           the handshake.
//  Latency: accept at edge T, hp_o/faint_o update at edge T+2, resp_valid high from T+2 (DONE).
//  Minimum 4 cycles per request with resp_ready tied high.
//  Init: honoured only in IDLE; ignored in other states. Init wins over req in the same cycle.
//  Sets hp=init_hp; faint = (init_hp==0). Out-of-range idx is ignored.
//  resp_err, resp_faint, resp_dmg, resp_hp drop to 0 when leaving DONE.
//  hp_o/faint_o never change outside APPLY, init, or reset.
// TESTING
//  1 Reset: hp_o all 63, faint_o 0, req_ready 1 one cycle after reset_n rises.
//  2 EFF_TABLE entry{1,0}=01, atk 9 def 3, hp[0]=63 -> resp_dmg 20, resp_hp 43, resp_valid at T+2.
//  3 Default table, atk 3 def 3, init hp[1]=12 -> dmg 12, resp_hp 0, resp_faint 1, faint_o[1] 1.
//  4 Attack fainted ch1, or atk_idx==def_idx -> resp_err 1, dmg 0, hp_o unchanged.
//  5 Hold resp_ready 0 for 5 cycles -> resp_* stable, req_ready 0. Init pulses meanwhile are ignored.
//  6 reset_n low during LOOKUP -> no resp_valid; all hp 63; new request after reset completes normally.

Source files
------------

// File: rtl/battle_hp_engine.sv
// Multi-channel HP engine: one attack per valid/ready transaction, with a type-effectiveness
// lookup, a stat bonus and a saturating HP subtraction, plus sticky faint tracking per channel.
module battle_hp_engine #(
  parameter int NUM_POKE  = 2,
  parameter int HP_W      = 6,
  parameter int STAT_W    = 4,
  parameter int MAX_HP    = 63,
  parameter int DMG_HI    = 16,
  parameter int DMG_MID   = 12,
  parameter int DMG_LO    = 8,
  parameter int DMG_STEP  = 4,
  parameter logic [127:0] EFF_TABLE = '0,
  localparam int IDX_W = (NUM_POKE > 2) ? $clog2(NUM_POKE) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     init_valid,
  input  logic [IDX_W-1:0]         init_idx,
  input  logic [HP_W-1:0]          init_hp,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [IDX_W-1:0]         req_atk_idx,
  input  logic [IDX_W-1:0]         req_def_idx,
  input  logic [STAT_W-1:0]        req_atk,
  input  logic [STAT_W-1:0]        req_def,
  input  logic [2:0]               req_atk_typ,
  input  logic [2:0]               req_def_typ,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [HP_W-1:0]          resp_dmg,
  output logic [HP_W-1:0]          resp_hp,
  output logic                     resp_faint,
  output logic                     resp_err,
  output logic [NUM_POKE*HP_W-1:0] hp_o,
  output logic [NUM_POKE-1:0]      faint_o
);

  typedef enum logic [1:0] {IDLE, LOOKUP, APPLY, DONE} state_t;

  state_t state, state_n;

  logic [IDX_W-1:0]  a_idx, d_idx;
  logic [STAT_W-1:0] atk_r, def_r;
  logic [2:0]        atyp_r, dtyp_r;
  logic [HP_W-1:0]   dmg_r;
  logic [HP_W-1:0]   hp [NUM_POKE];
  logic [NUM_POKE-1:0] faint;

  logic              accept;
  logic              init_hit;
  logic [1:0]        eff_code;
  logic [HP_W:0]     base, sum;
  logic [HP_W-1:0]   dmg_c;
  logic              a_ok, d_ok, err_c, kill_c;
  logic [HP_W-1:0]   def_hp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reset_n && !init_valid;
        if (req_valid && req_ready) state_n = LOOKUP;
      end
      LOOKUP: state_n = APPLY;
      APPLY:  state_n = DONE;
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign init_hit = (state == IDLE) && init_valid && (32'(init_idx) < NUM_POKE);

  // Damage is computed one bit wider than HP so the stat bonus can saturate instead of wrapping.
  always_comb begin
    eff_code = EFF_TABLE[{atyp_r, dtyp_r, 1'b0} +: 2];
    base     = '0;
    case (eff_code)
      2'b00:   base = (HP_W+1)'(DMG_MID);
      2'b01:   base = (HP_W+1)'(DMG_HI);
      2'b10:   base = (HP_W+1)'(DMG_LO);
      default: base = '0;
    endcase
    sum = base;
    if (eff_code != 2'b11 && atk_r > def_r) sum = base + (HP_W+1)'(DMG_STEP);
    dmg_c = sum[HP_W] ? '1 : sum[HP_W-1:0];
  end

  always_comb begin
    a_ok   = 32'(a_idx) < NUM_POKE;
    d_ok   = 32'(d_idx) < NUM_POKE;
    def_hp = d_ok ? hp[d_idx] : '0;
    err_c  = !a_ok || !d_ok || (a_idx == d_idx) || faint[a_idx] || faint[d_idx];
    kill_c = !err_c && (def_hp <= dmg_r) && (dmg_r != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_idx  <= '0;
      d_idx  <= '0;
      atk_r  <= '0;
      def_r  <= '0;
      atyp_r <= '0;
      dtyp_r <= '0;
      dmg_r  <= '0;
    end else begin
      if (accept) begin
        a_idx  <= req_atk_idx;
        d_idx  <= req_def_idx;
        atk_r  <= req_atk;
        def_r  <= req_def;
        atyp_r <= req_atk_typ;
        dtyp_r <= req_def_typ;
      end
      if (state == LOOKUP) dmg_r <= dmg_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_POKE; k++) hp[k] <= HP_W'(MAX_HP);
      faint <= '0;
    end else if (init_hit) begin
      hp[init_idx]    <= init_hp;
      faint[init_idx] <= (init_hp == '0);
    end else if (state == APPLY && !err_c) begin
      if (kill_c) begin
        hp[d_idx]    <= '0;
        faint[d_idx] <= 1'b1;
      end else begin
        hp[d_idx] <= def_hp - dmg_r;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_dmg   <= '0;
      resp_hp    <= '0;
      resp_faint <= 1'b0;
      resp_err   <= 1'b0;
    end else if (state == APPLY) begin
      resp_err   <= err_c;
      resp_faint <= kill_c;
      resp_dmg   <= err_c ? '0 : dmg_r;
      resp_hp    <= err_c ? def_hp : (kill_c ? '0 : def_hp - dmg_r);
    end else if (state == DONE && resp_ready) begin
      resp_dmg   <= '0;
      resp_hp    <= '0;
      resp_faint <= 1'b0;
      resp_err   <= 1'b0;
    end
  end

  always_comb begin
    hp_o = '0;
    for (int unsigned k = 0; k < NUM_POKE; k++) hp_o[k*HP_W +: HP_W] = hp[k];
  end

  assign faint_o = faint;

endmodule
